// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until CDB-snooped operands are complete, oldest-ready first.
// Issue->ex_valid is 2 edges with ready operands; a stalled ex_ready holds ex_* and frees nothing.
module alu_rs #(
  parameter int                ENTRIES = 4,
  parameter int                LOCK_W  = 4,
  parameter int                DATA_W  = 32,
  parameter int                OP_W    = 5,
  parameter logic [LOCK_W-1:0] NO_LOCK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [OP_W-1:0]   iss_op,
  input  logic [LOCK_W-1:0] iss_qj,
  input  logic [DATA_W-1:0] iss_vj,
  input  logic [LOCK_W-1:0] iss_qk,
  input  logic [DATA_W-1:0] iss_vk,
  input  logic [LOCK_W-1:0] iss_dest,
  input  logic [LOCK_W-1:0] cdb_alu_index,
  input  logic [DATA_W-1:0] cdb_alu_result,
  input  logic [LOCK_W-1:0] cdb_lsm_index,
  input  logic [DATA_W-1:0] cdb_lsm_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [LOCK_W-1:0] ex_dest
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int AGE_W = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [OP_W-1:0]    op_d   [ENTRIES];
  logic [LOCK_W-1:0]  qj_q   [ENTRIES];
  logic [LOCK_W-1:0]  qj_d   [ENTRIES];
  logic [DATA_W-1:0]  vj_q   [ENTRIES];
  logic [DATA_W-1:0]  vj_d   [ENTRIES];
  logic [LOCK_W-1:0]  qk_q   [ENTRIES];
  logic [LOCK_W-1:0]  qk_d   [ENTRIES];
  logic [DATA_W-1:0]  vk_q   [ENTRIES];
  logic [DATA_W-1:0]  vk_d   [ENTRIES];
  logic [LOCK_W-1:0]  dest_q [ENTRIES];
  logic [LOCK_W-1:0]  dest_d [ENTRIES];
  logic [AGE_W-1:0]   age_q  [ENTRIES];
  logic [AGE_W-1:0]   age_d  [ENTRIES];

  logic              ex_valid_q;
  logic [OP_W-1:0]   ex_op_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q;
  logic [LOCK_W-1:0] ex_dest_q;

  logic [ENTRIES-1:0] rdy;
  logic               free_found, any_rdy;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic [AGE_W-1:0]   sel_age;
  logic               iss_fire, out_load;
  logic [LOCK_W-1:0]  iss_qj_n, iss_qk_n;
  logic [DATA_W-1:0]  iss_vj_n, iss_vk_n;

  assign iss_ready = ~&busy_q;
  assign iss_fire  = iss_valid && iss_ready;
  assign out_load  = (!ex_valid_q || ex_ready) && any_rdy;

  always_comb begin
    rdy        = '0;
    free_found = 1'b0;
    free_idx   = '0;
    any_rdy    = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rdy[i] = busy_q[i] && (qj_q[i] == NO_LOCK) && (qk_q[i] == NO_LOCK);
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rdy[i] && (!any_rdy || age_q[i] > sel_age)) begin
        any_rdy = 1'b1;
        sel_idx = IDX_W'(i);
        sel_age = age_q[i];
      end
    end
  end

  // Same-cycle broadcast of an issued tag would otherwise be missed forever.
  always_comb begin
    iss_qj_n = iss_qj;
    iss_vj_n = iss_vj;
    iss_qk_n = iss_qk;
    iss_vk_n = iss_vk;
    if (iss_qj != NO_LOCK && iss_qj == cdb_alu_index) begin
      iss_qj_n = NO_LOCK;
      iss_vj_n = cdb_alu_result;
    end else if (iss_qj != NO_LOCK && iss_qj == cdb_lsm_index) begin
      iss_qj_n = NO_LOCK;
      iss_vj_n = cdb_lsm_result;
    end
    if (iss_qk != NO_LOCK && iss_qk == cdb_alu_index) begin
      iss_qk_n = NO_LOCK;
      iss_vk_n = cdb_alu_result;
    end else if (iss_qk != NO_LOCK && iss_qk == cdb_lsm_index) begin
      iss_qk_n = NO_LOCK;
      iss_vk_n = cdb_lsm_result;
    end
  end

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    qj_d   = qj_q;
    vj_d   = vj_q;
    qk_d   = qk_q;
    vk_d   = vk_q;
    dest_d = dest_q;
    age_d  = age_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i]) begin
        if (qj_q[i] != NO_LOCK && qj_q[i] == cdb_alu_index) begin
          qj_d[i] = NO_LOCK;
          vj_d[i] = cdb_alu_result;
        end else if (qj_q[i] != NO_LOCK && qj_q[i] == cdb_lsm_index) begin
          qj_d[i] = NO_LOCK;
          vj_d[i] = cdb_lsm_result;
        end
        if (qk_q[i] != NO_LOCK && qk_q[i] == cdb_alu_index) begin
          qk_d[i] = NO_LOCK;
          vk_d[i] = cdb_alu_result;
        end else if (qk_q[i] != NO_LOCK && qk_q[i] == cdb_lsm_index) begin
          qk_d[i] = NO_LOCK;
          vk_d[i] = cdb_lsm_result;
        end
        // Issue ages everyone up, dispatch closes the gap above the leaver; both cancel.
        if (iss_fire && !(out_load && age_q[i] > sel_age)) begin
          if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
        end else if (!iss_fire && out_load && age_q[i] > sel_age) begin
          age_d[i] = age_q[i] - 1'b1;
        end
        if (out_load && sel_idx == IDX_W'(i)) busy_d[i] = 1'b0;
      end
    end
    if (iss_fire) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = iss_op;
      qj_d[free_idx]   = iss_qj_n;
      vj_d[free_idx]   = iss_vj_n;
      qk_d[free_idx]   = iss_qk_n;
      vk_d[free_idx]   = iss_vk_n;
      dest_d[free_idx] = iss_dest;
      age_d[free_idx]  = '0;
    end
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
    op_q   <= op_d;
    qj_q   <= qj_d;
    vj_q   <= vj_d;
    qk_q   <= qk_d;
    vk_q   <= vk_d;
    dest_q <= dest_d;
    age_q  <= age_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_dest_q  <= NO_LOCK;
    end else if (out_load) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= op_q[sel_idx];
      ex_a_q     <= vj_q[sel_idx];
      ex_b_q     <= vk_q[sel_idx];
      ex_dest_q  <= dest_q[sel_idx];
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_dest  = ex_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, issue/capture/bypass, full station, age order, stall, flush.
module tb_alu_rs;
  localparam logic [3:0] NL = 4'hF;

  logic        clk = 1'b0;
  logic        rst, flush, iss_valid, iss_ready, ex_valid, ex_ready;
  logic [4:0]  iss_op, ex_op;
  logic [3:0]  iss_qj, iss_qk, iss_dest, cdb_alu_index, cdb_lsm_index, ex_dest;
  logic [31:0] iss_vj, iss_vk, cdb_alu_result, cdb_lsm_result, ex_a, ex_b;

  int total = 0;
  int bad   = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_qj(iss_qj), .iss_vj(iss_vj), .iss_qk(iss_qk), .iss_vk(iss_vk), .iss_dest(iss_dest),
    .cdb_alu_index(cdb_alu_index), .cdb_alu_result(cdb_alu_result),
    .cdb_lsm_index(cdb_lsm_index), .cdb_lsm_result(cdb_lsm_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_dest(ex_dest)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [3:0] qj, input logic [31:0] vj,
                             input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] dest);
    iss_valid = 1'b1;
    iss_op = op; iss_qj = qj; iss_vj = vj; iss_qk = qk; iss_vk = vk; iss_dest = dest;
  endtask

  task automatic drive_cdb(input logic [3:0] ai, input logic [31:0] ar,
                           input logic [3:0] li, input logic [31:0] lr);
    cdb_alu_index = ai; cdb_alu_result = ar; cdb_lsm_index = li; cdb_lsm_result = lr;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; ex_ready = 1'b0;
    iss_op = '0; iss_qj = NL; iss_vj = '0; iss_qk = NL; iss_vk = '0; iss_dest = '0;
    drive_cdb(NL, 0, NL, 0);
    repeat (2) step();
    rst = 1'b0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b want=0", ex_valid); end
    total++; if (ex_dest !== NL) begin bad++; $display("FAIL reset_ex_dest got=%h want=f", ex_dest); end
    total++; if (ex_a !== 32'd0 || ex_b !== 32'd0 || ex_op !== 5'd0) begin
      bad++; $display("FAIL reset_ex_data got op=%h a=%h b=%h want zeros", ex_op, ex_a, ex_b); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL reset_iss_ready got=%0b want=1", iss_ready); end
  endtask

  task automatic test_basic();
    ex_ready = 1'b1;
    drive_issue(5'd3, NL, 32'd5, NL, 32'd7, 4'd2);
    step();
    iss_valid = 1'b0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b1 || ex_op !== 5'd3 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_dest !== 4'd2) begin
      bad++; $display("FAIL basic_dispatch got v=%0b op=%0d a=%0d b=%0d d=%0d want 1/3/5/7/2", ex_valid, ex_op, ex_a, ex_b, ex_dest); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b want=0", ex_valid); end
  endtask

  task automatic test_capture();
    drive_issue(5'd1, 4'd6, 32'd0, NL, 32'd1, 4'd3);
    step();
    iss_valid = 1'b0;
    step(); step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL capture_wait got=%0b want=0", ex_valid); end
    drive_cdb(4'd6, 32'h10, NL, 0);
    step();
    drive_cdb(NL, 0, NL, 0);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL capture_same_cycle got=%0b want=0", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b1 || ex_a !== 32'h10 || ex_b !== 32'd1 || ex_dest !== 4'd3) begin
      bad++; $display("FAIL capture_dispatch got v=%0b a=%h b=%h d=%0d want 1/10/1/3", ex_valid, ex_a, ex_b, ex_dest); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL capture_drain got=%0b want=0", ex_valid); end
  endtask

  task automatic test_bypass();
    drive_issue(5'd2, 4'd9, 32'd0, NL, 32'd2, 4'd4);
    drive_cdb(NL, 0, 4'd9, 32'hAB);
    step();
    iss_valid = 1'b0;
    drive_cdb(NL, 0, NL, 0);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL bypass_early got=%0b want=0", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b1 || ex_a !== 32'hAB || ex_b !== 32'd2 || ex_dest !== 4'd4) begin
      bad++; $display("FAIL bypass_dispatch got v=%0b a=%h b=%h d=%0d want 1/ab/2/4", ex_valid, ex_a, ex_b, ex_dest); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL bypass_drain got=%0b want=0", ex_valid); end
  endtask

  task automatic test_full_age();
    for (int i = 0; i < 4; i++) begin
      drive_issue(5'd4, 4'(10 + i), 32'd0, NL, 32'(i), 4'(i));
      step();
    end
    iss_valid = 1'b0;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL full_iss_ready got=%0b want=0", iss_ready); end
    drive_issue(5'd5, NL, 32'h99, NL, 32'd0, 4'd9);
    step(); step();
    iss_valid = 1'b0;
    total++; if (ex_valid !== 1'b0 || iss_ready !== 1'b0) begin
      bad++; $display("FAIL full_ignore got v=%0b rdy=%0b want 0/0", ex_valid, iss_ready); end
    drive_cdb(4'd13, 32'h30, 4'd11, 32'h31);
    step();
    drive_cdb(NL, 0, NL, 0);
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL age_capture_edge got=%0b want=0", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd1 || ex_a !== 32'h31 || ex_b !== 32'd1) begin
      bad++; $display("FAIL age_first got v=%0b d=%0d a=%h b=%h want 1/1/31/1", ex_valid, ex_dest, ex_a, ex_b); end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL age_free_ready got=%0b want=1", iss_ready); end
    step();
    total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd3 || ex_a !== 32'h30 || ex_b !== 32'd3) begin
      bad++; $display("FAIL age_second got v=%0b d=%0d a=%h b=%h want 1/3/30/3", ex_valid, ex_dest, ex_a, ex_b); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL age_drain got=%0b want=0", ex_valid); end
  endtask

  task automatic test_stall();
    ex_ready = 1'b0;
    drive_cdb(4'd10, 32'h40, 4'd12, 32'h42);
    step();
    drive_cdb(NL, 0, NL, 0);
    step();
    total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd0 || ex_a !== 32'h40) begin
      bad++; $display("FAIL stall_load got v=%0b d=%0d a=%h want 1/0/40", ex_valid, ex_dest, ex_a); end
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd0 || ex_a !== 32'h40 || ex_b !== 32'd0) begin
        bad++; $display("FAIL stall_hold cyc=%0d got v=%0b d=%0d a=%h want 1/0/40", k, ex_valid, ex_dest, ex_a); end
    end
    ex_ready = 1'b1;
    step();
    total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd2 || ex_a !== 32'h42 || ex_b !== 32'd2) begin
      bad++; $display("FAIL stall_release got v=%0b d=%0d a=%h want 1/2/42", ex_valid, ex_dest, ex_a); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b want=0", ex_valid); end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    drive_issue(5'd6, 4'd7, 32'd0, NL, 32'd0, 4'd6); step();
    drive_issue(5'd6, 4'd8, 32'd0, NL, 32'd0, 4'd7); step();
    drive_issue(5'd7, NL, 32'h55, NL, 32'h66, 4'd5); step();
    drive_issue(5'd6, 4'd9, 32'd0, NL, 32'd0, 4'd8); step();
    iss_valid = 1'b0;
    total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd5 || ex_a !== 32'h55) begin
      bad++; $display("FAIL flush_pre got v=%0b d=%0d a=%h want 1/5/55", ex_valid, ex_dest, ex_a); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (ex_valid !== 1'b0 || ex_dest !== NL || iss_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear got v=%0b d=%h rdy=%0b want 0/f/1", ex_valid, ex_dest, iss_ready); end
    ex_ready = 1'b1;
    drive_cdb(4'd7, 32'h70, 4'd8, 32'h80); step();
    drive_cdb(4'd9, 32'h90, NL, 0); step();
    drive_cdb(NL, 0, NL, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_no_dispatch cyc=%0d got=%0b want=0", k, ex_valid); end
    end
    for (int i = 0; i < 3; i++) begin
      drive_issue(5'd8, 4'(1 + i), 32'd0, NL, 32'd0, 4'(i));
      step();
    end
    total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL flush_three_free got=%0b want=1", iss_ready); end
    drive_issue(5'd8, 4'd4, 32'd0, NL, 32'd0, 4'd3);
    step();
    iss_valid = 1'b0;
    total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL flush_refill_full got=%0b want=0", iss_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_bypass();
    test_full_age();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- ALU reservation station: the receiving end of the common data bus broadcast.
- Accepts decoded ALU ops from the dispatcher with operands either as values or as producer tags.
- Snoops both CDB broadcast channels (ALU result, load/store result) and captures tagged operands.
- Selects one ready entry per cycle and dispatches it to the ALU through a registered valid/ready output stage.

Parameters:
- ENTRIES, 4, number of station entries (power of two, 2..8).
- LOCK_W, 4, producer-tag width (ROB entry index plus spare bit).
- DATA_W, 32, operand/result width.
- OP_W, 5, ALU opcode width.
- NO_LOCK, 4'b1111 (all ones of LOCK_W), tag meaning "operand already valid / no broadcast".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; clears all entries and the output stage.
- iss_valid  in  1  dispatcher presents an op.
- iss_ready  out  1  station can accept (at least one free entry).
- iss_op  in  OP_W  opcode.
- iss_qj  in  LOCK_W  tag of operand A; NO_LOCK means iss_vj is valid.
- iss_vj  in  DATA_W  operand A value.
- iss_qk  in  LOCK_W  tag of operand B; NO_LOCK means iss_vk is valid.
- iss_vk  in  DATA_W  operand B value.
- iss_dest  in  LOCK_W  ROB tag of this op's result.
- cdb_alu_index  in  LOCK_W  ALU broadcast tag; NO_LOCK means idle.
- cdb_alu_result  in  DATA_W  ALU broadcast value.
- cdb_lsm_index  in  LOCK_W  load/store broadcast tag; NO_LOCK means idle.
- cdb_lsm_result  in  DATA_W  load/store broadcast value.
- ex_valid  out  1  dispatch to ALU valid.
- ex_ready  in  1  ALU accepts.
- ex_op  out  OP_W  opcode.
- ex_a  out  DATA_W  operand A.
- ex_b  out  DATA_W  operand B.
- ex_dest  out  LOCK_W  result tag.

Behaviour:
- Entry fields: busy, op, qj, vj, qk, vk, dest, age (log2 ENTRIES + 1 bits).
- Reset/flush: all busy=0. ex_valid=0; ex_op/ex_a/ex_b=0; ex_dest=NO_LOCK. iss_ready=1 after reset.
- Flush has priority over issue, capture and dispatch in the same cycle.
- iss_ready = any entry not busy. Combinational from state only, never from iss_valid.
- Issue (iss_valid && iss_ready): write into the lowest-index free entry at the edge.
- Issue bypass: if an issued tag equals a CDB tag presented in the same cycle (and that tag != NO_LOCK), store the broadcast value and set q=NO_LOCK.
  - cdb_alu wins over cdb_lsm if both match; that is a protocol error and must not occur.
- Capture: each cycle, every busy entry with qj (or qk) equal to a non-NO_LOCK CDB tag loads that result and sets its q=NO_LOCK at the edge.
  - Both operands may capture in the same cycle, from the same or different channels.
- Ready: busy && qj==NO_LOCK && qk==NO_LOCK, evaluated on registered state. A value captured at edge t is selectable in the cycle after t, not the same cycle.
- Select: the oldest ready entry (largest age); ties are impossible.
  - Age: the issued entry gets age 0.
  - All other busy entries increment age on issue, saturating.
  - Dispatching an entry decrements the age of every busy entry older than it.
- Output stage: load when (!ex_valid || ex_ready) and a ready entry exists.
  - Selected fields go into ex_*, ex_valid=1, and the entry frees at the same edge.
  - If ex_valid && ex_ready and no entry is ready: ex_valid=0.
  - While ex_valid && !ex_ready: ex_* hold stable and no entry frees.
- Latency: op issued with both operands valid at edge t -> ex_valid high after edge t+1.
- Full: with all entries busy, iss_ready=0 and iss_valid is ignored. An entry freed at edge t makes iss_ready=1 after edge t.
- Simultaneous issue and dispatch into a full station: issue is not accepted that cycle (iss_ready reflects pre-edge state).
- The output stage does not snoop the CDB; its operands are complete by construction.

Test Plan:
- Reset, then issue op=3, qj=qk=NO_LOCK, vj=5, vk=7, dest=2 with ex_ready=1 -> two edges later ex_valid=1, ex_a=5, ex_b=7, ex_dest=2; next cycle ex_valid=0.
- Issue qj=6, qk=NO_LOCK, vk=1; three cycles later cdb_alu_index=6, result=0x10 -> ex_valid one edge after capture edge, ex_a=0x10.
- Issue with qj=9 while cdb_lsm_index=9, result=0xAB in the same cycle (bypass) -> entry ready at once, ex_a=0xAB.
- Fill 4 entries with qj waiting; iss_ready=0, extra iss_valid ignored. Broadcast tags so entries 3 then 1 become ready -> dispatch order follows age (older issue first); iss_ready returns 1 after first free.
- Hold ex_ready=0 for 5 cycles with two ready entries -> ex_* stable, one dispatch per ex_ready cycle after release.
- Assert flush with 3 busy entries and ex_valid=1 -> next cycle ex_valid=0, iss_ready=1, later CDB broadcasts produce no dispatch.
